// File: rtl/interp_upsample.sv
// Stereo linear-interpolation upsampler: one output per sample_tick, interpolated between the two
// most recent low-rate inputs. Optional round-half-up build: define INTERP_ROUND_EN.
module interp_upsample #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned MAXLOG2 = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             sample_tick,
  input  logic [2:0]       ratio_log2,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] inleft,
  input  logic [WIDTH-1:0] inright,
  output logic             in_ready,
  output logic [WIDTH-1:0] outleft,
  output logic [WIDTH-1:0] outright,
  output logic             out_valid,
  output logic             underrun,
  output logic             overflow
);

  // Wide enough for (curr - prev) * phase without overflow in the signed multiply.
  localparam int unsigned PW = WIDTH + MAXLOG2 + 2;
  localparam logic [MAXLOG2:0]   CntOne = {{MAXLOG2{1'b0}}, 1'b1};
  localparam logic [MAXLOG2-1:0] PhOne  = {{(MAXLOG2-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {StEmpty, StPrime, StRun} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   prev_l_q, prev_l_d, prev_r_q, prev_r_d;
  logic [WIDTH-1:0]   curr_l_q, curr_l_d, curr_r_q, curr_r_d;
  logic [WIDTH-1:0]   pend_l_q, pend_l_d, pend_r_q, pend_r_d;
  logic               pend_full_q, pend_full_d;
  logic [MAXLOG2-1:0] phase_q, phase_d;
  logic [2:0]         r_act_q, r_act_d;
  logic [WIDTH-1:0]   out_l_q, out_l_d, out_r_q, out_r_d;
  logic               out_valid_q, out_valid_d;
  logic               underrun_q, underrun_d;
  logic               overflow_q, overflow_d;

  logic [2:0]         r_new;
  logic [MAXLOG2:0]   ratio_cnt;
  logic [MAXLOG2:0]   phase_inc;
  logic               wrap;
  logic               consume;
  logic               direct;

  function automatic logic signed [PW-1:0] sext(input logic [WIDTH-1:0] v);
    return {{(PW-WIDTH){v[WIDTH-1]}}, v};
  endfunction

  function automatic logic [WIDTH-1:0] interp(input logic [WIDTH-1:0]   prev,
                                              input logic [WIDTH-1:0]   curr,
                                              input logic [MAXLOG2-1:0] phase,
                                              input logic [2:0]         r);
    logic signed [PW-1:0] d, p, ph, rnd, sum;
    d   = sext(curr) - sext(prev);
    ph  = $signed({{(PW-MAXLOG2){1'b0}}, phase});
    p   = d * ph;
    rnd = '0;
`ifdef INTERP_ROUND_EN
    if (r != 3'd0) rnd[r - 3'd1] = 1'b1;
`endif
    sum = sext(prev) + ((p + rnd) >>> r);
    return WIDTH'(sum);
  endfunction

  assign r_new     = (ratio_log2 > 3'(MAXLOG2)) ? 3'(MAXLOG2) : ratio_log2;
  assign ratio_cnt = CntOne << r_act_q;
  assign phase_inc = {1'b0, phase_q} + CntOne;
  assign wrap      = (phase_inc == ratio_cnt);

  always_comb begin
    state_d     = state_q;
    prev_l_d    = prev_l_q;
    prev_r_d    = prev_r_q;
    curr_l_d    = curr_l_q;
    curr_r_d    = curr_r_q;
    pend_l_d    = pend_l_q;
    pend_r_d    = pend_r_q;
    pend_full_d = pend_full_q;
    phase_d     = phase_q;
    r_act_d     = r_act_q;
    out_l_d     = out_l_q;
    out_r_d     = out_r_q;
    out_valid_d = sample_tick;
    underrun_d  = underrun_q;
    overflow_d  = overflow_q;
    consume     = 1'b0;
    direct      = 1'b0;

    unique case (state_q)
      StEmpty: begin
        if (sample_tick) begin
          out_l_d = '0;
          out_r_d = '0;
        end
        if (pend_full_q) begin
          curr_l_d = pend_l_q;
          curr_r_d = pend_r_q;
          consume  = 1'b1;
          state_d  = StPrime;
        end
      end
      StPrime: begin
        if (sample_tick) begin
          out_l_d = curr_l_q;
          out_r_d = curr_r_q;
        end
        if (pend_full_q) begin
          prev_l_d = curr_l_q;
          prev_r_d = curr_r_q;
          curr_l_d = pend_l_q;
          curr_r_d = pend_r_q;
          consume  = 1'b1;
          phase_d  = '0;
          r_act_d  = r_new;
          state_d  = StRun;
        end
      end
      StRun: begin
        if (sample_tick) begin
          out_l_d = interp(prev_l_q, curr_l_q, phase_q, r_act_q);
          out_r_d = interp(prev_r_q, curr_r_q, phase_q, r_act_q);
          if (wrap) begin
            phase_d  = '0;
            r_act_d  = r_new;
            prev_l_d = curr_l_q;
            prev_r_d = curr_r_q;
            if (pend_full_q) begin
              curr_l_d = pend_l_q;
              curr_r_d = pend_r_q;
              consume  = 1'b1;
            end else if (in_valid) begin
              // Arriving sample bypasses the pending slot.
              curr_l_d = inleft;
              curr_r_d = inright;
              direct   = 1'b1;
            end else begin
              underrun_d = 1'b1;
            end
          end else begin
            phase_d = phase_q + PhOne;
          end
        end
      end
      default: state_d = StEmpty;
    endcase

    if (consume) pend_full_d = 1'b0;
    // A slot freed this cycle can take the incoming sample without flagging overflow.
    if (in_valid && !direct) begin
      if (!pend_full_d) begin
        pend_l_d    = inleft;
        pend_r_d    = inright;
        pend_full_d = 1'b1;
      end else begin
        overflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StEmpty;
      prev_l_q    <= '0;
      prev_r_q    <= '0;
      curr_l_q    <= '0;
      curr_r_q    <= '0;
      pend_l_q    <= '0;
      pend_r_q    <= '0;
      pend_full_q <= 1'b0;
      phase_q     <= '0;
      r_act_q     <= '0;
      out_l_q     <= '0;
      out_r_q     <= '0;
      out_valid_q <= 1'b0;
      underrun_q  <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      prev_l_q    <= prev_l_d;
      prev_r_q    <= prev_r_d;
      curr_l_q    <= curr_l_d;
      curr_r_q    <= curr_r_d;
      pend_l_q    <= pend_l_d;
      pend_r_q    <= pend_r_d;
      pend_full_q <= pend_full_d;
      phase_q     <= phase_d;
      r_act_q     <= r_act_d;
      out_l_q     <= out_l_d;
      out_r_q     <= out_r_d;
      out_valid_q <= out_valid_d;
      underrun_q  <= underrun_d;
      overflow_q  <= overflow_d;
    end
  end

  assign in_ready  = ~pend_full_q;
  assign outleft   = out_l_q;
  assign outright  = out_r_q;
  assign out_valid = out_valid_q;
  assign underrun  = underrun_q;
  assign overflow  = overflow_q;

endmodule
